// File: rtl/accel_op_scheduler.sv
// Command sequencer for the 8-bit math datapath: command FIFO -> single-issue execute -> result FIFO.
// Build macro ACCEL_SCHED_DIVZ_EN short-circuits opcode 3 with B = 0 to 16'hFFFF and adds a sticky dz flag.
module accel_op_scheduler #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  address,
  input  logic        data_write,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [7:0]  mp_a,
  output logic [7:0]  mp_b,
  output logic [3:0]  mp_opcode,
  input  logic [15:0] mp_result,
  output logic        busy,
  output logic        irq
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [3:0]    LAT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    lat_cnt_q;
  logic [7:0]    mp_a_q;
  logic [7:0]    mp_b_q;
  logic [3:0]    mp_op_q;

  logic [7:0]    a_stage_q;
  logic [7:0]    b_stage_q;
  logic [3:0]    last_op_q;
  logic          ovf_q;
  logic          udf_q;
`ifdef ACCEL_SCHED_DIVZ_EN
  logic          divz_q;
  logic          dz_q;
`endif

  // Command entries are packed {A[19:12], B[11:4], opcode[3:0]}
  logic [19:0]   cmd_mem_q [DEPTH];
  logic [PW-1:0] cmd_rd_q;
  logic [PW-1:0] cmd_wr_q;
  logic [CW-1:0] cmd_cnt_q;
  logic [15:0]   res_mem_q [DEPTH];
  logic [PW-1:0] res_rd_q;
  logic [PW-1:0] res_wr_q;
  logic [CW-1:0] res_cnt_q;

  logic [19:0]   cmd_head_s;
  logic [15:0]   res_head_s;
  logic          wr_push_s;
  logic          wr_pop_s;
  logic          wr_clr_s;
  logic          cmd_pop_s;
  logic          cmd_push_s;
  logic          res_pop_s;
  logic          res_push_s;
  logic          head_divz_s;
  logic [15:0]   res_data_s;
  logic          flag7_s;
  logic [7:0]    status_s;

  // FIFO handshakes; the internal command pop is resolved before a software push so a full FIFO can accept
  always_comb begin
    cmd_head_s  = cmd_mem_q[cmd_rd_q];
    res_head_s  = res_mem_q[res_rd_q];
    wr_push_s   = data_write && (address == 4'h4);
    wr_pop_s    = data_write && (address == 4'h7);
    wr_clr_s    = data_write && (address == 4'h9);
    cmd_pop_s   = (state_q == IDLE) && (cmd_cnt_q != '0) && (res_cnt_q != FULL_CNT);
    cmd_push_s  = wr_push_s && ((cmd_cnt_q != FULL_CNT) || cmd_pop_s);
    res_pop_s   = wr_pop_s && (res_cnt_q != '0);
    res_push_s  = (state_q == WB) && ((res_cnt_q != FULL_CNT) || res_pop_s);
`ifdef ACCEL_SCHED_DIVZ_EN
    head_divz_s = (cmd_head_s[3:0] == 4'd3) && (cmd_head_s[11:4] == 8'd0);
    res_data_s  = divz_q ? 16'hFFFF : mp_result;
    flag7_s     = dz_q;
`else
    head_divz_s = 1'b0;
    res_data_s  = mp_result;
    flag7_s     = ovf_q;
`endif
    status_s    = {flag7_s, udf_q, 3'(res_cnt_q), 3'(cmd_cnt_q)};
  end

  // Issue sequencer: operands stay on mp_* from pop until the next pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_cnt_q <= 4'd0;
      mp_a_q    <= 8'd0;
      mp_b_q    <= 8'd0;
      mp_op_q   <= 4'd0;
`ifdef ACCEL_SCHED_DIVZ_EN
      divz_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_pop_s) begin
            mp_a_q    <= cmd_head_s[19:12];
            mp_b_q    <= cmd_head_s[11:4];
            mp_op_q   <= cmd_head_s[3:0];
            lat_cnt_q <= LAT_LOAD;
            state_q   <= head_divz_s ? WB : EXEC;
`ifdef ACCEL_SCHED_DIVZ_EN
            divz_q    <= head_divz_s;
`endif
          end
        end
        EXEC: begin
          if (lat_cnt_q == 4'd0) begin
            state_q <= WB;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        WB: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Staging registers, FIFO storage/pointers/counts and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_stage_q <= 8'd0;
      b_stage_q <= 8'd0;
      last_op_q <= 4'd0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
`ifdef ACCEL_SCHED_DIVZ_EN
      dz_q      <= 1'b0;
`endif
      cmd_rd_q  <= '0;
      cmd_wr_q  <= '0;
      cmd_cnt_q <= '0;
      res_rd_q  <= '0;
      res_wr_q  <= '0;
      res_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cmd_mem_q[i] <= 20'd0;
        res_mem_q[i] <= 16'd0;
      end
    end else begin
      if (data_write && (address == 4'h0)) a_stage_q <= data_in;
      if (data_write && (address == 4'h1)) b_stage_q <= data_in;
      if (wr_push_s) last_op_q <= data_in[3:0];

      ovf_q <= (ovf_q && !wr_clr_s) || (wr_push_s && !cmd_push_s);
      udf_q <= (udf_q && !wr_clr_s) || (wr_pop_s && !res_pop_s);
`ifdef ACCEL_SCHED_DIVZ_EN
      dz_q  <= (dz_q && !wr_clr_s) || (res_push_s && divz_q);
`endif

      if (cmd_push_s) begin
        cmd_mem_q[cmd_wr_q] <= {a_stage_q, b_stage_q, data_in[3:0]};
        cmd_wr_q            <= cmd_wr_q + PTR_ONE;
      end
      if (cmd_pop_s) cmd_rd_q <= cmd_rd_q + PTR_ONE;
      case ({cmd_push_s, cmd_pop_s})
        2'b10:   cmd_cnt_q <= cmd_cnt_q + CNT_ONE;
        2'b01:   cmd_cnt_q <= cmd_cnt_q - CNT_ONE;
        default: cmd_cnt_q <= cmd_cnt_q;
      endcase

      if (res_push_s) begin
        res_mem_q[res_wr_q] <= res_data_s;
        res_wr_q            <= res_wr_q + PTR_ONE;
      end
      if (res_pop_s) res_rd_q <= res_rd_q + PTR_ONE;
      case ({res_push_s, res_pop_s})
        2'b10:   res_cnt_q <= res_cnt_q + CNT_ONE;
        2'b01:   res_cnt_q <= res_cnt_q - CNT_ONE;
        default: res_cnt_q <= res_cnt_q;
      endcase
    end
  end

  // Register read mux; an empty result FIFO reads as zero
  always_comb begin
    case (address)
      4'h0:    data_out = a_stage_q;
      4'h1:    data_out = b_stage_q;
      4'h4:    data_out = {4'd0, last_op_q};
      4'h5:    data_out = (res_cnt_q != '0) ? res_head_s[7:0] : 8'h00;
      4'h6:    data_out = (res_cnt_q != '0) ? res_head_s[15:8] : 8'h00;
      4'h8:    data_out = status_s;
`ifdef ACCEL_SCHED_DIVZ_EN
      4'hA:    data_out = {7'd0, ovf_q};
`endif
      default: data_out = 8'h00;
    endcase
  end

  assign mp_a      = mp_a_q;
  assign mp_b      = mp_b_q;
  assign mp_opcode = mp_op_q;
  assign busy      = (state_q != IDLE) || (cmd_cnt_q != '0);
  assign irq       = (res_cnt_q != '0);

endmodule

// File: doc/accel_op_scheduler.md
Name: accel_op_scheduler

Overview:
Command sequencer for the 8-bit math datapath (add/sub/mul/div/and/or/xor, 4-bit opcode, 16-bit result).
- Software pushes {A,B,opcode} commands into a small command FIFO through the peripheral register interface.
- The block issues commands to the datapath one at a time, waits a fixed settle latency, and captures each result into a result FIFO that software pops.
- It sits between the TinyQV peripheral bus and the combinational math unit.

Parameters:
DEPTH, 4, entries in each FIFO (power of two, 2..8).
LATENCY, 2, cycles operands are held stable on the datapath before the result is sampled (1..15).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
address  in  4  register address
data_write  in  1  write strobe, one cycle per write
data_in  in  8  write data
data_out  out  8  read data, combinational from address
mp_a  out  8  operand A to datapath
mp_b  out  8  operand B to datapath
mp_opcode  out  4  opcode to datapath
mp_result  in  16  datapath result
busy  out  1  high when a command is in flight or queued
irq  out  1  high while result FIFO non-empty

Behaviour:
Register map:
- 0x0: A staging, R/W.
- 0x1: B staging, R/W.
- 0x4: write pushes {A_stage, B_stage, data_in[3:0]} into the command FIFO; read returns last opcode written.
- 0x5: read returns result FIFO head [7:0].
- 0x6: read returns result FIFO head [15:8].
- 0x7: any write pops the result FIFO.
- 0x8: status = {ovf, udf, res_cnt[2:0], cmd_cnt[2:0]}.
- 0x9: any write clears ovf and udf.
- Other addresses read 0.
- Empty result FIFO reads 0 at 0x5/0x6.

Reset:
- All state cleared: FIFOs empty, counts 0, flags 0, FSM in IDLE.
- mp_a, mp_b, mp_opcode = 0; busy = 0; irq = 0.
- Asynchronous assertion; reset mid-operation discards in-flight and queued commands.

FSM states IDLE, EXEC, WB:
- IDLE: if command FIFO is non-empty and result FIFO is not full, pop the head into the operand registers driving mp_*, load counter = LATENCY-1, go to EXEC. Operands appear on mp_* the cycle after the pop.
- EXEC: counter decrements each cycle; at 0, go to WB.
- WB: push mp_result into the result FIFO, go to IDLE.
- mp_* hold their last values in IDLE.
- Throughput: one command per LATENCY+2 cycles.
- Latency: push to result visible = LATENCY+2 cycles when idle.

Boundary rules:
- Push to a full command FIFO: command dropped, ovf set (sticky).
- Pop of an empty result FIFO: ignored, udf set (sticky).
- Result FIFO full: FSM stalls in IDLE; the command stays queued.
- Simultaneous push and internal pop on a full command FIFO: the pop happens first, so the push succeeds.
- Simultaneous WB push and software pop on a full result FIFO: both take effect, count unchanged.
- Pointers wrap modulo DEPTH; counts range 0..DEPTH.
- busy = (state != IDLE) or cmd_cnt != 0.
- irq = res_cnt != 0.

Optional Feature:
ACCEL_SCHED_DIVZ_EN:
- Defined:
  - A command with opcode 3 and B = 0 skips EXEC: IDLE pops it, then WB pushes 16'hFFFF.
  - The sticky bit dz is set and reported in status bit 7 in place of ovf.
  - ovf moves to a new read address 0xA bit 0.
  - A write to 0x9 clears dz too.
- Undefined: divide-by-zero is issued normally and mp_result is captured as-is; the status map is as above.

Test Plan:
- Reset, then read 0x8 -> 0x00; busy=0, irq=0, mp_a=mp_b=0.
- Write A=200 (0x0), B=100 (0x1), push op 2 (0x4); wait LATENCY+2 -> irq=1, 0x5 reads 0x20, 0x6 reads 0x4E (20000); write 0x7 -> irq=0.
- Push 5 ADD commands (A=i, B=1, i=1..5) back-to-back while idle with DEPTH=4 -> first four results 2,3,4,5 popped in order; the fifth is dropped only if the FIFO was full at push. Check ovf against cmd_cnt timing.
- Queue 6 commands with no pops -> FSM stalls with res_cnt=4, remaining commands held; pop one -> the next executes within LATENCY+2 cycles.
- Write 0x7 with the result FIFO empty -> udf=1 (status bit 6); write 0x9 -> status flags 0.
- A=9, B=0, op 3: with ACCEL_SCHED_DIVZ_EN -> result 0xFFFF and dz=1 after 2 cycles; without it -> result equals the datapath's output for 9/0 and no flag is set.
- Assert rst_n low during EXEC -> all outputs 0 immediately; after release, status reads 0x00.
